// File: rtl/mux_lut_loader.sv
// Duplicate-free key/data table feeding the lookup mux, loaded over a valid/ready port and cleared by a walk.
// Optional feature: define MUX_LUT_LOADER_UPDATE_EN to let a write to an existing key overwrite its data.
module mux_lut_loader #(
  parameter int                  NR_KEY   = 2,
  parameter int                  KEY_LEN  = 1,
  parameter int                  DATA_LEN = 1,
  parameter logic [KEY_LEN-1:0]  FILL_KEY = '0
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      wr_valid,
  output logic                                      wr_ready,
  input  logic [KEY_LEN-1:0]                        wr_key,
  input  logic [DATA_LEN-1:0]                       wr_data,
  input  logic                                      clr,
  output logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]      lut,
  output logic [$clog2(NR_KEY+1)-1:0]               count,
  output logic                                      full,
  output logic                                      busy,
  output logic                                      err
);

  localparam int P  = KEY_LEN + DATA_LEN;
  localparam int CW = $clog2(NR_KEY + 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state_q, state_d;
  logic [KEY_LEN-1:0]    key_q  [NR_KEY];
  logic [KEY_LEN-1:0]    key_d  [NR_KEY];
  logic [DATA_LEN-1:0]   data_q [NR_KEY];
  logic [DATA_LEN-1:0]   data_d [NR_KEY];
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         idx_q, idx_d;
  logic                  err_q, err_d;
  logic [NR_KEY-1:0]     hit_vec;
  logic                  hit;

  assign wr_ready = (state_q == IDLE) && !clr;
  assign busy     = (state_q == CLEAR);
  assign full     = (count_q == CW'(NR_KEY));
  assign count    = count_q;
  assign err      = err_q;

  always_comb begin
    lut = '0;
    for (int i = 0; i < NR_KEY; i++) lut[P*i +: P] = {key_q[i], data_q[i]};
  end

  // Only slots below count take part in matching; parked slots never hit.
  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NR_KEY; i++)
      hit_vec[i] = (CW'(i) < count_q) && (key_q[i] == wr_key);
    hit = |hit_vec;
  end

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latch).
    key_d   = key_q;
    data_d  = data_q;
    count_d = count_q;
    idx_d   = idx_q;
    state_d = state_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          count_d = '0;
          idx_d   = '0;
        end else if (wr_valid) begin
          if (wr_key == FILL_KEY) begin
            err_d = 1'b1;
          end else if (hit) begin
`ifdef MUX_LUT_LOADER_UPDATE_EN
            for (int i = 0; i < NR_KEY; i++)
              if (hit_vec[i]) data_d[i] = wr_data;
`else
            err_d = 1'b1;
`endif
          end else if (!full) begin
            for (int i = 0; i < NR_KEY; i++)
              if (CW'(i) == count_q) begin
                key_d[i]  = wr_key;
                data_d[i] = wr_data;
              end
            count_d = count_q + CW'(1);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        for (int i = 0; i < NR_KEY; i++)
          if (CW'(i) == idx_q) begin
            key_d[i]  = FILL_KEY;
            data_d[i] = '0;
          end
        if (clr) begin
          idx_d = '0;
        end else if (idx_q == CW'(NR_KEY - 1)) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the table itself is reset so it is parked on FILL_KEY at once; this is a register file, not a RAM.
      for (int i = 0; i < NR_KEY; i++) begin
        key_q[i]  <= FILL_KEY;
        data_q[i] <= '0;
      end
      count_q <= '0;
      idx_q   <= '0;
      state_q <= IDLE;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      key_q   <= key_d;
      data_q  <= data_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_mux_lut_loader.sv
// Self-checking bench for mux_lut_loader: directed scenarios plus random traffic against a table model.
module tb_mux_lut_loader;

  localparam int NR = 4;
  localparam int KL = 4;
  localparam int DL = 8;
  localparam logic [KL-1:0] FK = 4'hF;

  logic              clk = 1'b0;
  logic              rst, wr_valid, wr_ready, clr, full, busy, err;
  logic [KL-1:0]     wr_key;
  logic [DL-1:0]     wr_data;
  logic [NR*12-1:0]  lut;
  logic [2:0]        count;

  int n_cmp  = 0;
  int n_fail = 0;
  bit run    = 1'b0;

  mux_lut_loader #(.NR_KEY(NR), .KEY_LEN(KL), .DATA_LEN(DL), .FILL_KEY(FK)) dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_key(wr_key),
    .wr_data(wr_data), .clr(clr), .lut(lut), .count(count), .full(full), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: a table of slots, a count of live entries and the number of clear cycles still owed.
  logic [KL-1:0] m_key  [NR];
  logic [DL-1:0] m_data [NR];
  int m_count, m_clear_left;
  bit m_err;

  always @(posedge clk) begin
    int found;
    m_err = 1'b0;
    if (rst) begin
      for (int i = 0; i < NR; i++) begin m_key[i] = FK; m_data[i] = '0; end
      m_count = 0;
      m_clear_left = 0;
    end else if (m_clear_left > 0) begin
      m_key[NR - m_clear_left]  = FK;
      m_data[NR - m_clear_left] = '0;
      m_clear_left = clr ? NR : m_clear_left - 1;
    end else if (clr) begin
      m_count = 0;
      m_clear_left = NR;
    end else if (wr_valid) begin
      found = -1;
      for (int i = 0; i < m_count; i++) if (m_key[i] == wr_key) found = i;
      if (wr_key == FK) m_err = 1'b1;
      else if (found >= 0) begin
`ifdef MUX_LUT_LOADER_UPDATE_EN
        m_data[found] = wr_data;
`else
        m_err = 1'b1;
`endif
      end else if (m_count < NR) begin
        m_key[m_count]  = wr_key;
        m_data[m_count] = wr_data;
        m_count++;
      end else m_err = 1'b1;
    end
  end

  always @(negedge clk) begin
    logic [NR*12-1:0] exp_lut;
    if (run) begin
      for (int i = 0; i < NR; i++) exp_lut[12*i +: 12] = {m_key[i], m_data[i]};
      check("lut", 64'(lut), 64'(exp_lut));
      check("count", 64'(count), 64'(m_count));
      check("full", 64'(full), 64'(m_count == NR));
      check("busy", 64'(busy), 64'(m_clear_left > 0));
      check("err", 64'(err), 64'(m_err));
      check("wr_ready", 64'(wr_ready), 64'((m_clear_left == 0) && !clr));
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [KL-1:0] k, input logic [DL-1:0] d, input logic c);
    wr_valid = v; wr_key = k; wr_data = d; clr = c;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    tick(); tick();
    rst = 1'b0;
    run = 1'b1;
    // Reset state
    check("rst_lut", 64'(lut), 64'h0000_F00F_00F0_0F00);
    check("rst_count", 64'(count), 64'd0);
    check("rst_ready", 64'(wr_ready), 64'd1);
    check("rst_busy_err", 64'({busy, err, full}), 64'd0);

    // Fill the table back-to-back, then overflow
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, KL'(k), DL'(k * 8'h11), 1'b0);
      tick();
      check("fill_count", 64'(count), 64'(k));
    end
    check("fill_full", 64'(full), 64'd1);
    drive(1'b1, 4'h5, 8'h55, 1'b0);
    tick();
    check("ovf_err", 64'(err), 64'd1);
    drive(1'b0, '0, '0, 1'b0);
    tick();
    check("ovf_err_drop", 64'(err), 64'd0);
    check("ovf_lut", 64'(lut), 64'h0000_4443_3322_2111);

    // Existing key
    drive(1'b1, 4'h2, 8'hAA, 1'b0);
    tick();
`ifdef MUX_LUT_LOADER_UPDATE_EN
    check("upd_slot1", 64'(lut[23:12]), 64'h2AA);
    check("upd_err", 64'(err), 64'd0);
`else
    check("upd_slot1", 64'(lut[23:12]), 64'h222);
    check("upd_err", 64'(err), 64'd1);
`endif
    check("upd_count", 64'(count), 64'd4);

    // Fill key is never accepted
    drive(1'b1, FK, 8'h77, 1'b0);
    tick();
    check("fk_err", 64'(err), 64'd1);
    check("fk_count", 64'(count), 64'd4);

    // Clear walk, with a write offered alongside clr
    drive(1'b1, 4'h9, 8'h99, 1'b1);
    #1;
    check("clr_ready_low", 64'(wr_ready), 64'd0);
    tick();
    check("clr_count", 64'(count), 64'd0);
    drive(1'b1, 4'h6, 8'h66, 1'b0);
    for (int j = 0; j < NR; j++) begin
      check("clr_busy", 64'(busy), 64'd1);
      check("clr_ready", 64'(wr_ready), 64'd0);
      tick();
      check("clr_slot", 64'(lut[12*j +: 12]), 64'hF00);
    end
    check("clr_done", 64'(busy), 64'd0);
    check("clr_nowrite", 64'(count), 64'd0);
    drive(1'b0, '0, '0, 1'b0);
    tick();

    // Reset in the middle of a clear
    for (int k = 7; k <= 9; k++) begin
      drive(1'b1, KL'(k), DL'(k), 1'b0);
      tick();
    end
    drive(1'b0, '0, '0, 1'b1);
    tick();
    drive(1'b0, '0, '0, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b1, FK, 8'h01, 1'b0);
    tick();
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    check("mid_rst_lut", 64'(lut), 64'h0000_F00F_00F0_0F00);
    check("mid_rst_state", 64'({count, busy, err}), 64'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0, KL'($urandom_range(0, 15)), DL'($urandom),
            (m_clear_left == 0) && ($urandom_range(0, 29) == 0));
      tick();
    end
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
